csa_accum_pipe: RTL and testbench
=================================

Name: csa_accum_pipe

Overview:
- Parametrised successor to the Vector ALU's fixed 24-bit two-operand adder.
- Sums NUM_OPS unsigned WIDTH-bit operands through a 3:2 carry-save compressor tree, then does one carry-propagate add.
- Two-stage elastic pipeline with valid/ready handshakes.
- Adds an optional internal accumulator. Feeds VALU reduction and dot-product lanes.

Parameters:
- WIDTH, 24, bit width of each input operand.
- NUM_OPS, 4, operand count per transaction; legal range 2..8.
- GUARD, 8, extra high-order bits on result and accumulator; OUT_W = WIDTH+GUARD.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_ops  in  NUM_OPS*WIDTH  packed operands; operand k at bits [k*WIDTH +: WIDTH].
- in_mode  in  2  0 SUM, 1 ACC, 2 LOAD, 3 CLEAR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  OUT_W  result, modulo 2^OUT_W.
- out_ovf  out  1  true result of this transaction was >= 2^OUT_W.
- acc_value  out  OUT_W  current accumulator register.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid(out_valid)=0, out_sum=0, out_ovf=0, acc=0, stage-1 data=0.
- Reset mid-operation drops all in-flight transactions. No result is emitted for them.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Once out_valid is high, out_sum and out_ovf are held stable until transferred.
- Stage 1:
  - Combinational 3:2 tree reduces the NUM_OPS zero-extended operands to OUT_W-bit vectors S1_S and S1_C.
  - These are registered together with the mode.
  - s1_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv. Combinational from out_ready; no combinational path from in_valid.
- Stage 2:
  - On s1_adv, addend A is selected by mode: acc in ACC mode, 0 otherwise.
  - One further 3:2 stage reduces S1_S, S1_C and A to two vectors.
  - A CPA then produces OUT_W+1 bits. The low OUT_W bits go to out_sum. The MSB is ORed with any tree carry lost above OUT_W and goes to out_ovf.
  - The overflow computation must be exact for the unsigned true sum.
- Mode effects (all applied on the s1_adv edge):
  - SUM: result = Σops; acc unchanged.
  - ACC: result = acc + Σops; acc <= result.
  - LOAD: result = Σops; acc <= result.
  - CLEAR: result = 0, out_ovf = 0; acc <= 0; ops ignored.
- Back-to-back ACC transactions use the acc value updated by the previous transaction. No bubble is required.
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 transaction per cycle while out_ready is held high.
- Back-pressure:
  - out_ready low with s2 full stalls stage 2.
  - Stage 1 then holds. in_ready drops only when s1 is also full.
  - Results are never dropped, duplicated or reordered.
- Simultaneous events: if out transfers and s1 advances in the same cycle, s2 reloads; out_valid stays high.
- Wrap-around: acc wraps modulo 2^OUT_W. out_ovf is per-transaction and not sticky.

Decomposition:
- Shared package valu_pkg holds:
  - mode encodings MODE_SUM/ACC/LOAD/CLEAR;
  - a function for the tree depth of NUM_OPS;
  - OUT_W derivation.
- Natural sub-module: csa_3to2_vec, a parametrised OUT_W-bit row of full adders.
  - It is instantiated per tree level in stage 1 and once in stage 2.
  - The existing fulladder cell is reused inside it.

Test Plan:
- Plain sum (WIDTH=24, NUM_OPS=4, SUM): ops 0xFFFFFF, 0xFFFFFF, 0x000001, 0x000002 -> out_sum=0x2000001, out_ovf=0, acc stays 0, result 2 cycles after accept.
- Accumulate stream: LOAD {5,0,0,0}, then ACC {1,2,3,4} issued back-to-back -> results 5 then 15, acc=15, no bubble.
- Overflow and wrap: LOAD {0xFFFFFF×4}, then repeated ACC {0xFFFFFF×4} -> out_ovf=1 on the first ACC whose true sum reaches >= 2^32, out_sum equals the true sum mod 2^32.
- Back-pressure: out_ready=0 for 5 cycles with in_valid high -> exactly 2 transactions accepted, in_ready low, out_sum stable; release -> all results in order, none lost.
- CLEAR and reset mid-flight: CLEAR with ops {7,7,7,7} -> out_sum=0, acc=0. Assert rst while s1 and s2 are full -> out_valid=0 and acc=0 immediately (asynchronous), no stale result after release.
- Parameter sweep: NUM_OPS=2,3,8 with random operands vs a reference model -> exact match of out_sum and out_ovf.

Source files
------------

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared VALU definitions: modes, widths, compressor tree sizing
// Mode encodings and constant functions that size the 3:2 carry-save tree.
package valu_pkg;

   typedef enum logic [1:0] {
      MODE_SUM   = 2'd0,
      MODE_ACC   = 2'd1,
      MODE_LOAD  = 2'd2,
      MODE_CLEAR = 2'd3
   } mode_e;

   function automatic int out_width(input int width, input int guard);
      return width + guard;
   endfunction

   // Each level turns every full group of three rows into two and passes the rest through.
   function automatic int level_count(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) begin
         c = 2 * (c / 3) + (c % 3);
      end
      return c;
   endfunction

   function automatic int tree_depth(input int n);
      int c;
      int d;
      c = n;
      d = 0;
      for (int i = 0; i < 16; i++) begin
         if (c > 2) begin
            c = 2 * (c / 3) + (c % 3);
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/csa_3to2_vec.sv
// rtl/csa_3to2_vec.sv - W-bit 3:2 carry-save compressor row
// Carry vector is pre-shifted into place; the carry leaving the top bit is reported on lost.
module csa_3to2_vec #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry,
   output logic         lost
);

   logic [W-1:0] co;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fulladder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (co[i])
      );
   end

   assign carry = {co[W-2:0], 1'b0};
   assign lost  = co[W-1];

endmodule

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
// Shared leaf cell of the carry-save rows.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/csa_accum_pipe.sv
// rtl/csa_accum_pipe.sv - multi-operand carry-save adder with accumulator, 2-stage elastic pipe
// Stage 1 compresses NUM_OPS operands to sum/carry rows; stage 2 folds in the accumulator and resolves.
module csa_accum_pipe
   import valu_pkg::*;
#(
   parameter  int WIDTH   = 24,
   parameter  int NUM_OPS = 4,
   parameter  int GUARD   = 8,
   localparam int OUT_W   = out_width(WIDTH, GUARD)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] in_ops,
   input  logic [1:0]               in_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_sum,
   output logic                     out_ovf,
   output logic [OUT_W-1:0]         acc_value
);

   localparam int DEPTH = tree_depth(NUM_OPS);

   // tree[l][k] is row k entering level l; tree[DEPTH][0..1] are the final sum/carry rows.
   logic [OUT_W-1:0]            tree [0:DEPTH][0:NUM_OPS-1];
   logic [DEPTH:0][NUM_OPS-1:0] lost;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
      assign tree[0][k] = OUT_W'(in_ops[k*WIDTH +: WIDTH]);
   end

   assign lost[DEPTH] = '0;

   for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
      localparam int CNT = level_count(NUM_OPS, l);
      localparam int NG  = CNT / 3;
      localparam int REM = CNT % 3;

      for (genvar k = 0; k < NUM_OPS; k++) begin : g_row
         if (k < NG) begin : g_csa
            csa_3to2_vec #(.W(OUT_W)) u_csa (
               .a     (tree[l][3*k]),
               .b     (tree[l][3*k+1]),
               .c     (tree[l][3*k+2]),
               .sum   (tree[l+1][2*k]),
               .carry (tree[l+1][2*k+1]),
               .lost  (lost[l][k])
            );
         end else begin : g_nocsa
            assign lost[l][k] = 1'b0;
         end

         if (k >= 2*NG && k < 2*NG + REM) begin : g_pass
            assign tree[l+1][k] = tree[l][k+NG];
         end else if (k >= 2*NG + REM) begin : g_zero
            assign tree[l+1][k] = '0;
         end
      end
   end

   logic             s1_valid_q, s1_valid_d;
   logic [OUT_W-1:0] s1_s_q, s1_s_d;
   logic [OUT_W-1:0] s1_c_q, s1_c_d;
   logic             s1_lost_q, s1_lost_d;
   mode_e            s1_mode_q, s1_mode_d;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_sum_q, out_sum_d;
   logic             out_ovf_q, out_ovf_d;
   logic [OUT_W-1:0] acc_q, acc_d;

   logic             s1_adv;
   logic             in_fire;
   logic [OUT_W-1:0] addend;
   logic [OUT_W-1:0] s2_s;
   logic [OUT_W-1:0] s2_c;
   logic             s2_lost;
   logic [OUT_W:0]   cpa;
   logic [OUT_W-1:0] res_sum;
   logic             res_ovf;

   csa_3to2_vec #(.W(OUT_W)) u_csa_s2 (
      .a     (s1_s_q),
      .b     (s1_c_q),
      .c     (addend),
      .sum   (s2_s),
      .carry (s2_c),
      .lost  (s2_lost)
   );

   always_comb begin
      s1_adv  = s1_valid_q && (!out_valid_q || out_ready);
      in_fire = in_valid && (!s1_valid_q || s1_adv);

      s1_valid_d = s1_valid_q;
      s1_s_d     = s1_s_q;
      s1_c_d     = s1_c_q;
      s1_lost_d  = s1_lost_q;
      s1_mode_d  = s1_mode_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_s_d     = tree[DEPTH][0];
         s1_c_d     = tree[DEPTH][1];
         s1_lost_d  = |lost;
         s1_mode_d  = mode_e'(in_mode);
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      addend = (s1_mode_q == MODE_ACC) ? acc_q : '0;
      cpa    = {1'b0, s2_s} + {1'b0, s2_c};

      // Any carry dropped off the top of either compressor stage means the true sum overflowed.
      if (s1_mode_q == MODE_CLEAR) begin
         res_sum = '0;
         res_ovf = 1'b0;
      end else begin
         res_sum = cpa[OUT_W-1:0];
         res_ovf = cpa[OUT_W] | s2_lost | s1_lost_q;
      end

      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      acc_d       = acc_q;
      if (s1_adv) begin
         out_valid_d = 1'b1;
         out_sum_d   = res_sum;
         out_ovf_d   = res_ovf;
         case (s1_mode_q)
            MODE_ACC, MODE_LOAD: acc_d = res_sum;
            MODE_CLEAR:          acc_d = '0;
            default:             acc_d = acc_q;
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_s_q      <= '0;
         s1_c_q      <= '0;
         s1_lost_q   <= 1'b0;
         s1_mode_q   <= MODE_SUM;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_s_q      <= s1_s_d;
         s1_c_q      <= s1_c_d;
         s1_lost_q   <= s1_lost_d;
         s1_mode_q   <= s1_mode_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
         acc_q       <= acc_d;
      end
   end

   assign in_ready  = !s1_valid_q || s1_adv;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;
   assign acc_value = acc_q;

endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb/tb_csa_accum_pipe.sv - scoreboard bench for csa_accum_pipe
// Directed vectors on the default build plus NUM_OPS=8 and NUM_OPS=3 builds with narrow guards.
module tb_csa_accum_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [95:0] in_ops;
   logic [1:0]  in_mode;
   logic [31:0] out_sum, acc_value;

   logic        a8_in_valid, a8_in_ready, a8_out_valid, a8_out_ready, a8_out_ovf;
   logic [63:0] a8_in_ops;
   logic [1:0]  a8_in_mode;
   logic [9:0]  a8_out_sum, a8_acc_value;

   logic        a3_in_valid, a3_in_ready, a3_out_valid, a3_out_ready, a3_out_ovf;
   logic [11:0] a3_in_ops;
   logic [1:0]  a3_in_mode;
   logic [4:0]  a3_out_sum, a3_acc_value;

   csa_accum_pipe #(.WIDTH(24), .NUM_OPS(4), .GUARD(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
      .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .acc_value(acc_value)
   );

   csa_accum_pipe #(.WIDTH(8), .NUM_OPS(8), .GUARD(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(a8_in_valid), .in_ready(a8_in_ready), .in_ops(a8_in_ops),
      .in_mode(a8_in_mode), .out_valid(a8_out_valid), .out_ready(a8_out_ready),
      .out_sum(a8_out_sum), .out_ovf(a8_out_ovf), .acc_value(a8_acc_value)
   );

   csa_accum_pipe #(.WIDTH(4), .NUM_OPS(3), .GUARD(1)) dut3 (
      .clk(clk), .rst(rst), .in_valid(a3_in_valid), .in_ready(a3_in_ready), .in_ops(a3_in_ops),
      .in_mode(a3_in_mode), .out_valid(a3_out_valid), .out_ready(a3_out_ready),
      .out_sum(a3_out_sum), .out_ovf(a3_out_ovf), .acc_value(a3_acc_value)
   );

   localparam logic [1:0] M_SUM = 2'd0, M_ACC = 2'd1, M_LOAD = 2'd2, M_CLR = 2'd3;

   typedef struct packed { logic [31:0] sum; logic ovf; logic [31:0] acc; } exp_t;
   typedef struct packed { logic [9:0]  sum; logic ovf; logic [9:0]  acc; } exp8_t;
   typedef struct packed { logic [4:0]  sum; logic ovf; logic [4:0]  acc; } exp3_t;

   exp_t  sb  [$];
   exp8_t sb8 [$];
   exp3_t sb3 [$];
   exp_t  em;
   exp8_t em8;
   exp3_t em3;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: output with empty scoreboard", name);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) unexpected("main_out");
         else begin
            em = sb.pop_front();
            check("main_sum", 64'(out_sum), 64'(em.sum));
            check("main_ovf", 64'(out_ovf), 64'(em.ovf));
            check("main_acc", 64'(acc_value), 64'(em.acc));
         end
      end
      if (!rst && a8_out_valid && a8_out_ready) begin
         if (sb8.size() == 0) unexpected("ops8_out");
         else begin
            em8 = sb8.pop_front();
            check("ops8_sum", 64'(a8_out_sum), 64'(em8.sum));
            check("ops8_ovf", 64'(a8_out_ovf), 64'(em8.ovf));
            check("ops8_acc", 64'(a8_acc_value), 64'(em8.acc));
         end
      end
      if (!rst && a3_out_valid && a3_out_ready) begin
         if (sb3.size() == 0) unexpected("ops3_out");
         else begin
            em3 = sb3.pop_front();
            check("ops3_sum", 64'(a3_out_sum), 64'(em3.sum));
            check("ops3_ovf", 64'(a3_out_ovf), 64'(em3.ovf));
            check("ops3_acc", 64'(a3_acc_value), 64'(em3.acc));
         end
      end
   end

   function automatic logic [95:0] pack4(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c, input logic [23:0] d);
      return {d, c, b, a};
   endfunction

   // Called just after a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic [1:0] m, input logic [95:0] ops,
                       input logic [31:0] es, input logic eo, input logic [31:0] ea);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_mode  = m;
      in_ops   = ops;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
      end else begin
         sb.push_back('{sum: es, ovf: eo, acc: ea});
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic send8(input logic [1:0] m, input logic [63:0] ops,
                        input logic [9:0] es, input logic eo, input logic [9:0] ea);
      a8_in_valid = 1'b1;
      a8_in_mode  = m;
      a8_in_ops   = ops;
      check("ops8_in_ready", 64'(a8_in_ready), 64'd1);
      sb8.push_back('{sum: es, ovf: eo, acc: ea});
      @(posedge clk);
      @(negedge clk);
      a8_in_valid = 1'b0;
   endtask

   task automatic send3(input logic [1:0] m, input logic [11:0] ops,
                        input logic [4:0] es, input logic eo, input logic [4:0] ea);
      a3_in_valid = 1'b1;
      a3_in_mode  = m;
      a3_in_ops   = ops;
      check("ops3_in_ready", 64'(a3_in_ready), 64'd1);
      sb3.push_back('{sum: es, ovf: eo, acc: ea});
      @(posedge clk);
      @(negedge clk);
      a3_in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() + sb8.size() + sb3.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(sb.size() + sb8.size() + sb3.size()), 64'd0);
      @(negedge clk);
   endtask

   logic [32:0] t;
   logic [31:0] acc_m;
   logic [31:0] held;
   int          accepted;
   logic        took;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_ops = '0; in_mode = M_SUM; out_ready = 1'b1;
      a8_in_valid = 1'b0; a8_in_ops = '0; a8_in_mode = M_SUM; a8_out_ready = 1'b1;
      a3_in_valid = 1'b0; a3_in_ops = '0; a3_in_mode = M_SUM; a3_out_ready = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);
      check("rst_acc", 64'(acc_value), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // plain sum and two-cycle latency
      send(M_SUM, pack4(24'hFFFFFF, 24'hFFFFFF, 24'h1, 24'h2), 32'h2000001, 1'b0, 32'h0);
      in_valid = 1'b0;
      check("latency_cycle1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("latency_cycle2", 64'(out_valid), 64'd1);
      wait_drain("drain_sum");

      // back-to-back LOAD then ACC with no bubble
      send(M_LOAD, pack4(24'd5, 24'd0, 24'd0, 24'd0), 32'd5, 1'b0, 32'd5);
      send(M_ACC, pack4(24'd1, 24'd2, 24'd3, 24'd4), 32'd15, 1'b0, 32'd15);
      in_valid = 1'b0;
      check("nobubble_first", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("nobubble_second", 64'(out_valid), 64'd1);
      wait_drain("drain_acc");
      check("acc_after_stream", 64'(acc_value), 64'd15);

      // accumulate 4*0xFFFFFF repeatedly until the 32-bit result wraps
      send(M_LOAD, pack4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), 32'h3FFFFFC, 1'b0, 32'h3FFFFFC);
      acc_m = 32'h3FFFFFC;
      for (int k = 1; k <= 65; k++) begin
         t = {1'b0, acc_m} + 33'h3FFFFFC;
         send(M_ACC, pack4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), t[31:0], t[32], t[31:0]);
         acc_m = t[31:0];
      end
      in_valid = 1'b0;
      wait_drain("drain_wrap");
      check("acc_after_wrap", 64'(acc_value), 64'h07FFFEF8);

      // CLEAR ignores operands
      send(M_CLR, pack4(24'd7, 24'd7, 24'd7, 24'd7), 32'd0, 1'b0, 32'd0);
      in_valid = 1'b0;
      wait_drain("drain_clear");

      // back-pressure: five stalled cycles with in_valid held high
      out_ready = 1'b0;
      accepted  = 0;
      held      = '0;
      in_valid  = 1'b1;
      in_mode   = M_SUM;
      in_ops    = pack4(24'd1, 24'd2, 24'd3, 24'd4);
      for (int c = 0; c < 5; c++) begin
         took = in_ready;
         if (took) begin
            if (accepted == 0) sb.push_back('{sum: 32'd10, ovf: 1'b0, acc: 32'd0});
            else sb.push_back('{sum: 32'h200000, ovf: 1'b0, acc: 32'd0});
         end
         @(posedge clk);
         @(negedge clk);
         if (took) begin
            accepted++;
            in_ops = (accepted == 1) ? pack4(24'h100000, 24'h100000, 24'd0, 24'd0)
                                     : pack4(24'h10, 24'd0, 24'd0, 24'd0);
         end
         if (c == 1) held = out_sum;
      end
      check("bp_accepted", 64'(accepted), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_stable", 64'(out_sum), 64'(held));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("drain_bp");

      // asynchronous reset with both stages full
      out_ready = 1'b0;
      send(M_LOAD, pack4(24'd9, 24'd0, 24'd0, 24'd0), 32'd9, 1'b0, 32'd9);
      send(M_SUM, pack4(24'd1, 24'd1, 24'd1, 24'd1), 32'd4, 1'b0, 32'd9);
      in_valid = 1'b0;
      check("prerst_acc", 64'(acc_value), 64'd9);
      check("prerst_in_ready", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_acc", 64'(acc_value), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("postrst_no_stale", 64'(out_valid), 64'd0);
      end

      // NUM_OPS=8, 8-bit operands, 10-bit result: stage-1 carries run off the top
      send8(M_SUM, {8{8'hFF}}, 10'h3F8, 1'b1, 10'h0);
      send8(M_SUM, 64'h0807060504030201, 10'h024, 1'b0, 10'h0);
      send8(M_SUM, 64'h7F80808080808080, 10'h3FF, 1'b0, 10'h0);
      send8(M_SUM, {8{8'h80}}, 10'h000, 1'b1, 10'h0);
      send8(M_LOAD, 64'h0000000080808080, 10'h200, 1'b0, 10'h200);
      send8(M_ACC, 64'h0000000080808080, 10'h000, 1'b1, 10'h000);
      send8(M_ACC, 64'h0000000000000005, 10'h005, 1'b0, 10'h005);

      // NUM_OPS=3, 4-bit operands, 5-bit result
      send3(M_SUM, 12'hFFF, 5'd13, 1'b1, 5'd0);
      send3(M_SUM, 12'h321, 5'd6, 1'b0, 5'd0);
      send3(M_LOAD, 12'h0FF, 5'd30, 1'b0, 5'd30);
      send3(M_ACC, 12'h011, 5'd0, 1'b1, 5'd0);
      wait_drain("drain_sweep");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
